// File: rtl/dot11_rx_ctrl.sv
// rtl/dot11_rx_ctrl.sv - paces IQ samples into dot11, owns its config registers and per-packet FSM.
// Optional build macro: DOT11_RX_CTRL_SKIP_EN adds SKIP_SAMPLE (address 6).
module dot11_rx_ctrl #(
    parameter int CLK_PER_SAMPLE = 10,
    parameter int RECOVER_CYCLES = 4,
    parameter int TIMEOUT_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [31:0] sample_out,
    output logic        sample_out_strobe,
    output logic        dot11_enable,
    output logic        dot11_reset,
    output logic [10:0] power_thres,
    output logic [31:0] min_plateau,
    output logic        soft_decoding,
    input  logic        short_preamble_detected,
    input  logic        legacy_sig_stb,
    input  logic        pkt_header_valid_strobe,
    input  logic        fcs_out_strobe,
    input  logic        fcs_ok,
    output logic [2:0]  state,
    output logic [15:0] pkt_ok_count,
    output logic [15:0] pkt_err_count,
    output logic [15:0] timeout_count,
    output logic [15:0] underrun_count
);

    localparam int DIV_W = $clog2(CLK_PER_SAMPLE + 1);
    localparam int REC_W = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_SEARCH  = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_enable;
    logic                   r_soft;
    logic [10:0]            r_power_shadow;
    logic [31:0]            r_min_shadow;
    logic [TIMEOUT_W-1:0]   r_timeout;
    logic [TIMEOUT_W-1:0]   r_to_cnt;
    logic [DIV_W-1:0]       r_div;
    logic [REC_W-1:0]       r_rec;
    logic [10:0]            r_power_out;
    logic [31:0]            r_min_out;
    logic [31:0]            r_sample;
    logic                   r_strobe;
    logic [15:0]            r_ok_cnt;
    logic [15:0]            r_err_cnt;
    logic [15:0]            r_to_evt_cnt;
    logic [15:0]            r_underrun_cnt;

    logic                   w_slot_end;
    logic                   w_fetch;
    logic                   w_underrun;
    logic                   w_drop;
    logic                   w_skip;
    logic                   w_timeout;
    logic                   w_clear;
    logic                   w_inc_ok;
    logic                   w_inc_err;
    logic                   w_inc_to;
    logic                   w_wr_ctrl;
    logic                   w_wr_power;
    logic                   w_wr_min;
    logic                   w_wr_timeout;
    logic                   w_enter_pkt;
    logic [10:0]            w_power_next;
    logic [31:0]            w_min_next;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    assign w_wr_ctrl    = set_stb && set_addr == 8'd0;
    assign w_wr_power   = set_stb && set_addr == 8'd1;
    assign w_wr_min     = set_stb && set_addr == 8'd2;
    assign w_wr_timeout = set_stb && set_addr == 8'd3;
    assign w_clear      = set_stb && set_addr == 8'd4;

    assign w_slot_end = r_enable && r_div == DIV_W'(CLK_PER_SAMPLE - 1);
    assign w_fetch    = w_slot_end && src_valid;
    assign w_underrun = w_slot_end && !src_valid;
    assign w_drop     = (r_state == S_RECOVER) || w_skip;
    assign w_timeout  = (r_timeout != '0) && (r_to_cnt == r_timeout);

`ifdef DOT11_RX_CTRL_SKIP_EN
    logic [15:0] r_skip_reg;
    logic [15:0] r_skip_cnt;

    // Skip budget reloads on every entry to S_SEARCH and drains on fetched samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_skip_reg <= '0;
            r_skip_cnt <= '0;
        end else begin
            if (set_stb && set_addr == 8'd6)
                r_skip_reg <= set_data[15:0];
            if (w_state_next == S_SEARCH && r_state != S_SEARCH)
                r_skip_cnt <= r_skip_reg;
            else if (w_fetch && r_skip_cnt != '0)
                r_skip_cnt <= r_skip_cnt - 16'd1;
        end
    end

    assign w_skip = r_skip_cnt != '0;
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_enable       <= 1'b0;
            r_soft         <= 1'b1;
            r_power_shadow <= '0;
            r_min_shadow   <= 32'd100;
            r_timeout      <= TIMEOUT_W'(16384);
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= set_data[0];
                r_soft   <= set_data[1];
            end
            if (w_wr_power)
                r_power_shadow <= set_data[10:0];
            if (w_wr_min)
                r_min_shadow <= set_data;
            if (w_wr_timeout)
                r_timeout <= set_data[TIMEOUT_W-1:0];
        end
    end

    // A write landing this cycle is folded in so it still appears one cycle after set_stb.
    assign w_power_next = w_wr_power ? set_data[10:0] : r_power_shadow;
    assign w_min_next   = w_wr_min   ? set_data       : r_min_shadow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_power_out <= '0;
            r_min_out   <= 32'd100;
        end else if (w_state_next == S_OFF || w_state_next == S_SEARCH) begin
            r_power_out <= w_power_next;
            r_min_out   <= w_min_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !r_enable || w_slot_end)
            r_div <= '0;
        else
            r_div <= r_div + DIV_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sample <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_fetch && !w_drop;
            if (w_fetch && !w_drop)
                r_sample <= src_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_OFF;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_inc_ok     = 1'b0;
        w_inc_err    = 1'b0;
        w_inc_to     = 1'b0;
        case (r_state)
            S_OFF: begin
                if (r_enable)
                    w_state_next = S_SEARCH;
            end
            S_SEARCH: begin
                if (short_preamble_detected)
                    w_state_next = S_HEADER;
            end
            S_HEADER: begin
                if (pkt_header_valid_strobe) begin
                    w_state_next = S_PAYLOAD;
                end else if (w_timeout) begin
                    w_inc_to     = 1'b1;
                    w_state_next = S_RECOVER;
                end
            end
            S_PAYLOAD: begin
                if (fcs_out_strobe) begin
                    w_inc_ok     = fcs_ok;
                    w_inc_err    = !fcs_ok;
                    w_state_next = S_RECOVER;
                end else if (w_timeout) begin
                    w_inc_to     = 1'b1;
                    w_state_next = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (r_rec == REC_W'(RECOVER_CYCLES - 1))
                    w_state_next = S_SEARCH;
            end
            default: w_state_next = S_OFF;
        endcase
        if (!r_enable)
            w_state_next = S_OFF;
    end

    assign w_enter_pkt = (w_state_next != r_state) &&
                         (w_state_next == S_HEADER || w_state_next == S_PAYLOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_rec    <= '0;
        end else begin
            if (w_enter_pkt || (r_state == S_HEADER && legacy_sig_stb))
                r_to_cnt <= '0;
            else if (r_strobe)
                r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
            r_rec <= (r_state == S_RECOVER) ? r_rec + REC_W'(1) : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_ok_cnt       <= '0;
            r_err_cnt      <= '0;
            r_to_evt_cnt   <= '0;
            r_underrun_cnt <= '0;
        end else begin
            r_ok_cnt       <= sat_inc(r_ok_cnt, w_inc_ok);
            r_err_cnt      <= sat_inc(r_err_cnt, w_inc_err);
            r_to_evt_cnt   <= sat_inc(r_to_evt_cnt, w_inc_to);
            r_underrun_cnt <= sat_inc(r_underrun_cnt, w_underrun);
        end
    end

    assign src_ready         = w_fetch;
    assign sample_out        = r_sample;
    assign sample_out_strobe = r_strobe;
    assign dot11_enable      = r_state != S_OFF;
    assign dot11_reset       = r_state == S_OFF || r_state == S_RECOVER;
    assign power_thres       = r_power_out;
    assign min_plateau       = r_min_out;
    assign soft_decoding     = r_soft;
    assign state             = r_state;
    assign pkt_ok_count      = r_ok_cnt;
    assign pkt_err_count     = r_err_cnt;
    assign timeout_count     = r_to_evt_cnt;
    assign underrun_count    = r_underrun_cnt;

endmodule

// File: tb/tb_dot11_rx_ctrl.sv
// tb/tb_dot11_rx_ctrl.sv - directed self-checking bench for dot11_rx_ctrl.
module tb_dot11_rx_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] sample_out;
    logic        sample_out_strobe;
    logic        dot11_enable;
    logic        dot11_reset;
    logic [10:0] power_thres;
    logic [31:0] min_plateau;
    logic        soft_decoding;
    logic        short_preamble_detected;
    logic        legacy_sig_stb;
    logic        pkt_header_valid_strobe;
    logic        fcs_out_strobe;
    logic        fcs_ok;
    logic [2:0]  state;
    logic [15:0] pkt_ok_count;
    logic [15:0] pkt_err_count;
    logic [15:0] timeout_count;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;

    dot11_rx_ctrl dut (
        .clock(clock), .reset(reset),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .sample_out(sample_out), .sample_out_strobe(sample_out_strobe),
        .dot11_enable(dot11_enable), .dot11_reset(dot11_reset),
        .power_thres(power_thres), .min_plateau(min_plateau), .soft_decoding(soft_decoding),
        .short_preamble_detected(short_preamble_detected), .legacy_sig_stb(legacy_sig_stb),
        .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .fcs_out_strobe(fcs_out_strobe), .fcs_ok(fcs_ok),
        .state(state), .pkt_ok_count(pkt_ok_count), .pkt_err_count(pkt_err_count),
        .timeout_count(timeout_count), .underrun_count(underrun_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(negedge clock);
        set_stb = 1'b0;
    endtask

    // Advances negedges until src_ready is seen; returns how many it took.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!src_ready && n < 40);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state != s && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic pulse_preamble();
        @(negedge clock) short_preamble_detected = 1'b1;
        @(negedge clock) short_preamble_detected = 1'b0;
    endtask

    initial begin
        int n;
        int strobes;
        int guard;
        logic [31:0] d;

        reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
        src_data = 32'h1111_0001; src_valid = 1'b1;
        short_preamble_detected = 1'b0; legacy_sig_stb = 1'b0;
        pkt_header_valid_strobe = 1'b0; fcs_out_strobe = 1'b0; fcs_ok = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_dot11_reset", {31'd0, dot11_reset}, 32'd1);
        check("rst_dot11_enable", {31'd0, dot11_enable}, 32'd0);
        check("rst_src_ready", {31'd0, src_ready}, 32'd0);
        check("rst_strobe", {31'd0, sample_out_strobe}, 32'd0);
        check("rst_min_plateau", min_plateau, 32'd100);
        check("rst_soft", {31'd0, soft_decoding}, 32'd1);
        check("rst_power", {21'd0, power_thres}, 32'd0);

        reg_write(8'd0, 32'd1);
        wait_ready(n);
        check("first_ready_found", {31'd0, src_ready}, 32'd1);
        check("state_search", {29'd0, state}, 32'd1);
        check("soft_cleared", {31'd0, soft_decoding}, 32'd0);
        check("dot11_enable_on", {31'd0, dot11_enable}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            d = src_data;
            @(negedge clock);
            check("strobe_after_ready", {31'd0, sample_out_strobe}, 32'd1);
            check("sample_value", sample_out, d);
            src_data = d + 32'h0001_0001;
            wait_ready(n);
            check("slot_period", n, 32'd9);
        end

        // Three empty slots, then the phase must be unchanged.
        @(negedge clock);
        src_valid = 1'b0;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (sample_out_strobe || src_ready) strobes++;
        end
        src_valid = 1'b1;
        check("underrun_no_strobes", strobes, 32'd0);
        check("underrun_count", {16'd0, underrun_count}, 32'd3);
        wait_ready(n);
        check("underrun_phase", n, 32'd9);

        pulse_preamble();
        check("state_header", {29'd0, state}, 32'd2);
        @(negedge clock) pkt_header_valid_strobe = 1'b1;
        @(negedge clock) pkt_header_valid_strobe = 1'b0;
        check("state_payload", {29'd0, state}, 32'd3);
        @(negedge clock) begin fcs_out_strobe = 1'b1; fcs_ok = 1'b1; end
        @(negedge clock) fcs_out_strobe = 1'b0;
        check("state_recover", {29'd0, state}, 32'd4);
        n = 0;
        while (state == 3'd4 && n < 20) begin
            if (dot11_reset) n++;
            @(negedge clock);
        end
        check("recover_cycles", n, 32'd4);
        check("back_to_search", {29'd0, state}, 32'd1);
        check("pkt_ok_1", {16'd0, pkt_ok_count}, 32'd1);

        reg_write(8'd3, 32'd50);
        pulse_preamble();
        strobes = 0; guard = 0;
        while (state != 3'd4 && guard < 1000) begin
            if (sample_out_strobe) strobes++;
            @(negedge clock);
            guard++;
        end
        check("timeout_samples", strobes, 32'd50);
        check("timeout_count_1", {16'd0, timeout_count}, 32'd1);
        wait_state(3'd1, "timeout_recovered");

        // FCS arrives on the very cycle the timeout would fire.
        pulse_preamble();
        @(negedge clock) pkt_header_valid_strobe = 1'b1;
        @(negedge clock) pkt_header_valid_strobe = 1'b0;
        strobes = 0; guard = 0;
        while (strobes < 50 && guard < 1000) begin
            if (sample_out_strobe) strobes++;
            if (strobes < 50) @(negedge clock);
            guard++;
        end
        @(negedge clock) begin fcs_out_strobe = 1'b1; fcs_ok = 1'b0; end
        @(negedge clock) fcs_out_strobe = 1'b0;
        check("coinc_state", {29'd0, state}, 32'd4);
        check("coinc_err", {16'd0, pkt_err_count}, 32'd1);
        check("coinc_timeout", {16'd0, timeout_count}, 32'd1);
        wait_state(3'd1, "coinc_recovered");

        pulse_preamble();
        @(negedge clock) pkt_header_valid_strobe = 1'b1;
        @(negedge clock) pkt_header_valid_strobe = 1'b0;
        reg_write(8'd1, 32'd200);
        repeat (3) @(negedge clock);
        check("power_held_payload", {21'd0, power_thres}, 32'd0);
        check("still_payload", {29'd0, state}, 32'd3);
        @(negedge clock) begin fcs_out_strobe = 1'b1; fcs_ok = 1'b1; end
        @(negedge clock) fcs_out_strobe = 1'b0;
        check("power_held_recover", {21'd0, power_thres}, 32'd0);
        wait_state(3'd1, "power_back_search");
        check("power_applied", {21'd0, power_thres}, 32'd200);
        check("pkt_ok_2", {16'd0, pkt_ok_count}, 32'd2);

        reg_write(8'd4, 32'd0);
        check("clr_ok", {16'd0, pkt_ok_count}, 32'd0);
        check("clr_err", {16'd0, pkt_err_count}, 32'd0);
        check("clr_timeout", {16'd0, timeout_count}, 32'd0);
        check("clr_underrun", {16'd0, underrun_count}, 32'd0);

        pulse_preamble();
        reg_write(8'd0, 32'd0);
        @(negedge clock);
        check("disable_state", {29'd0, state}, 32'd0);
        check("disable_reset", {31'd0, dot11_reset}, 32'd1);
        strobes = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (src_ready || sample_out_strobe) strobes++;
        end
        check("disabled_no_traffic", strobes, 32'd0);

        reg_write(8'd2, 32'd1234);
        check("min_plateau_off", min_plateau, 32'd1234);
        reg_write(8'd7, 32'hFFFF_FFFF);
        check("unknown_addr_min", min_plateau, 32'd1234);
        check("unknown_addr_power", {21'd0, power_thres}, 32'd200);

`ifdef DOT11_RX_CTRL_SKIP_EN
        reg_write(8'd6, 32'd5);
        reg_write(8'd0, 32'd1);
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            wait_ready(n);
            @(negedge clock);
            if (sample_out_strobe) strobes++;
        end
        check("skip_dropped", strobes, 32'd0);
        wait_ready(n);
        d = src_data;
        @(negedge clock);
        check("skip_sixth_fwd", {31'd0, sample_out_strobe}, 32'd1);
        check("skip_sixth_data", sample_out, d);
        check("skip_no_underrun", {16'd0, underrun_count}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot11_rx_ctrl.md
Name: dot11_rx_ctrl

Overview:
Receive-side controller in front of the dot11 receiver. It paces IQ samples from an upstream valid/ready source into dot11 at one sample per CLK_PER_SAMPLE clocks. It owns the dot11 configuration registers, written over a set_stb/set_addr/set_data bus, and drives dot11 enable and reset. A per-packet FSM tracks packet progress, enforces a timeout, resets dot11 between packets, and keeps packet statistics.

Parameters:
CLK_PER_SAMPLE, 10, clock cycles per sample slot (200 MHz / 20 MSPS)
RECOVER_CYCLES, 4, cycles dot11_reset is held in S_RECOVER
TIMEOUT_W, 16, width of the timeout register and counter

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
set_stb  in  1  register write strobe
set_addr  in  8  register address
set_data  in  32  register write data
src_data  in  32  I[31:16], Q[15:0] from upstream source
src_valid  in  1  source data available
src_ready  out  1  consume pulse to source
sample_out  out  32  sample to dot11 sample_in
sample_out_strobe  out  1  to dot11 sample_in_strobe
dot11_enable  out  1  to dot11 enable
dot11_reset  out  1  to dot11 reset
power_thres  out  11  to dot11
min_plateau  out  32  to dot11
soft_decoding  out  1  to dot11
short_preamble_detected  in  1  from dot11
legacy_sig_stb  in  1  from dot11
pkt_header_valid_strobe  in  1  from dot11
fcs_out_strobe  in  1  from dot11
fcs_ok  in  1  from dot11
state  out  3  FSM state
pkt_ok_count  out  16  saturating count of packets with FCS ok
pkt_err_count  out  16  saturating count of packets with FCS bad
timeout_count  out  16  saturating count of packet timeouts
underrun_count  out  16  saturating count of empty sample slots

Behaviour:
- Register map, write-only, applied the cycle after set_stb:
  - 0 CTRL: bit0 enable, bit1 soft_decoding.
  - 1 POWER_THRES [10:0].
  - 2 MIN_PLATEAU [31:0].
  - 3 PKT_TIMEOUT [TIMEOUT_W-1:0], in samples; 0 disables the timeout.
  - 4 CLEAR_STATS: any write zeroes all four counters.
  - Unknown addresses are ignored.
- Reset values:
  - Registers: enable 0, soft_decoding 1, power_thres 0, min_plateau 100, timeout 16384.
  - Outputs: src_ready 0, sample_out 0, sample_out_strobe 0, dot11_enable 0, dot11_reset 1, state S_OFF, all counters 0.
- Staged configuration:
  - Writes to POWER_THRES and MIN_PLATEAU land in shadow registers.
  - Shadows copy to the outputs only while state is S_OFF or S_SEARCH.
  - A write made mid-packet takes effect on the first cycle back in S_SEARCH.
- Pacing:
  - Slot counter div runs 0..CLK_PER_SAMPLE-1 and wraps; it runs continuously while enable=1 and is held at 0 otherwise.
  - At div==CLK_PER_SAMPLE-1 with src_valid=1: src_ready=1 for that cycle.
  - The next cycle, sample_out<=src_data and sample_out_strobe=1, unless the sample is dropped.
  - Dropped samples (S_RECOVER) are consumed from the source but not forwarded.
  - At div==CLK_PER_SAMPLE-1 with src_valid=0: no fetch, underrun_count+1, no retry before the next slot.
  - Latency from src_ready to sample_out_strobe is exactly 1 cycle.
- FSM, encoded S_OFF=0, S_SEARCH=1, S_HEADER=2, S_PAYLOAD=3, S_RECOVER=4:
  - S_OFF: dot11_enable=0, dot11_reset=1. Goes to S_SEARCH when enable=1.
  - S_SEARCH: dot11_enable=1. Goes to S_HEADER on short_preamble_detected.
  - S_HEADER: goes to S_PAYLOAD on pkt_header_valid_strobe. legacy_sig_stb restarts the timer.
  - S_PAYLOAD: on fcs_out_strobe, increments pkt_ok_count if fcs_ok, else pkt_err_count; then goes to S_RECOVER.
  - S_RECOVER: dot11_reset=1 for RECOVER_CYCLES cycles, then goes to S_SEARCH.
- Timeout:
  - The counter clears on entry to S_HEADER and S_PAYLOAD and increments on each forwarded sample.
  - When the count equals PKT_TIMEOUT (nonzero): timeout_count+1, then S_RECOVER.
- Boundary conditions:
  - fcs_out_strobe and timeout in the same cycle: the FCS result wins and no timeout is counted.
  - enable cleared in any state: S_OFF next cycle, dot11_reset=1, div cleared; any in-flight strobe completes.
  - CLEAR_STATS coincident with an increment: the clear wins.
  - Counters saturate at 0xFFFF.
  - Reset mid-packet: all state returns to reset values next cycle.

Optional Feature:
DOT11_RX_CTRL_SKIP_EN:
- Defined: adds register 6 SKIP_SAMPLE [15:0], reset value 0. On every entry to S_SEARCH, the first SKIP_SAMPLE fetched samples are consumed (src_ready pulses) but not forwarded. The skip does not count as underrun.
- Undefined: writes to address 6 are ignored and every sample outside S_RECOVER is forwarded.

Test Plan:
- Write CTRL=1, src_valid held 1 -> src_ready pulses every 10 cycles; sample_out_strobe follows 1 cycle later with sample_out==src_data; state=1.
- Toggle src_valid low for 3 slots -> 3 strobes missing, underrun_count=3, slot phase unchanged.
- Pulse short_preamble_detected, pkt_header_valid_strobe, then fcs_out_strobe with fcs_ok=1 -> states 2,3,4; dot11_reset high 4 cycles; pkt_ok_count=1; back to state 1.
- PKT_TIMEOUT=50, short preamble with no header -> state 4 after the 50th forwarded sample; timeout_count=1. Repeat with fcs_out_strobe coincident with the timeout -> pkt_err_count+1, timeout_count unchanged.
- Write POWER_THRES=200 while in state 3 -> power_thres stays 0 until state returns to 1, then reads 200.
- SKIP_EN build, SKIP_SAMPLE=5 -> after entering S_SEARCH, 5 src_ready pulses produce no strobe and the 6th is forwarded.
